// File: rtl/mixed_precision_sequencer.sv
// Multi-channel mixed-precision cycle sequencer: tracks the operand sub-word slice per channel.
// Optional wrap pulse output is built only when MPS_WRAP_PULSE_EN is defined.
module mixed_precision_sequencer #(
  parameter int NCH    = 2,
  parameter int CYC_W  = 3,
  parameter int SKIP_W = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   setback_i,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] ch_sel_i,
  input  logic [1:0]                             act_fmt_i,
  input  logic [1:0]                             wgt_fmt_i,
  input  logic [SKIP_W-1:0]                      skip_size_i,
  input  logic                                   dotp_valid_i,
  input  logic                                   csr_we_i,
  input  logic [CYC_W-1:0]                       csr_wdata_i,
  output logic [NCH*CYC_W-1:0]                   cycle_o,
  output logic [NCH-1:0]                         wcsr_o,
  output logic [NCH*2-1:0]                       mux_sel_o,
  output logic [NCH-1:0]                         wrap_o
);

  localparam int CS_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int LW   = (CYC_W > 4) ? CYC_W : 4;
  localparam logic [SKIP_W:0] SKIP_ONE = 1;

  typedef enum logic [1:0] {
    MPC_CSR       = 2'd0,
    MPC_CSR_WRITE = 2'd1,
    MPC_MIX_CNTRL = 2'd2
  } mpc_sel_e;

  logic [CYC_W-1:0]  cycle_q [NCH];
  logic [CYC_W-1:0]  cycle_d [NCH];
  logic [SKIP_W-1:0] skip_q  [NCH];
  logic [SKIP_W-1:0] skip_d  [NCH];
  mpc_sel_e          sel_q   [NCH];
  mpc_sel_e          sel_d   [NCH];
  logic [NCH-1:0]    wcsr_q, wcsr_d;
`ifdef MPS_WRAP_PULSE_EN
  logic [NCH-1:0]    wrap_q, wrap_d;
`endif

  // Cycle limit: one slice per narrow operand packed in the wide one, clamped to the counter range.
  logic [1:0]       fmt_diff;
  logic [LW-1:0]    ratio_max, cyc_max;
  logic [CYC_W-1:0] limit;
  logic [SKIP_W:0]  skip_inc [NCH];

  assign fmt_diff  = (act_fmt_i >= wgt_fmt_i) ? act_fmt_i - wgt_fmt_i : wgt_fmt_i - act_fmt_i;
  assign ratio_max = (LW'(1) << fmt_diff) - LW'(1);
  assign cyc_max   = LW'({CYC_W{1'b1}});
  assign limit     = (ratio_max > cyc_max) ? CYC_W'(cyc_max) : CYC_W'(ratio_max);

  always_comb begin
    // NOTE: every next-state signal takes a default before any branch, so no latch is inferred.
    wcsr_d = '0;
`ifdef MPS_WRAP_PULSE_EN
    wrap_d = '0;
`endif
    for (int c = 0; c < NCH; c++) begin
      cycle_d[c]  = cycle_q[c];
      skip_d[c]   = skip_q[c];
      sel_d[c]    = MPC_CSR;
      skip_inc[c] = {1'b0, skip_q[c]} + SKIP_ONE;
      if (ch_sel_i == CS_W'(c) && csr_we_i) begin
        cycle_d[c] = (csr_wdata_i <= limit) ? csr_wdata_i : '0;
        skip_d[c]  = '0;
        sel_d[c]   = MPC_CSR_WRITE;
      end else if (ch_sel_i == CS_W'(c) && dotp_valid_i) begin
        sel_d[c] = MPC_MIX_CNTRL;
        if (skip_inc[c] < {1'b0, skip_size_i}) begin
          skip_d[c] = skip_inc[c][SKIP_W-1:0];
        end else begin
          skip_d[c] = '0;
          if (limit != '0) begin
            wcsr_d[c] = 1'b1;
            if (cycle_q[c] >= limit) begin
              cycle_d[c] = '0;
`ifdef MPS_WRAP_PULSE_EN
              wrap_d[c]  = 1'b1;
`endif
            end else begin
              cycle_d[c] = cycle_q[c] + CYC_W'(1);
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || setback_i) begin
      for (int c = 0; c < NCH; c++) begin
        cycle_q[c] <= '0;
        skip_q[c]  <= '0;
        sel_q[c]   <= MPC_CSR;
      end
      wcsr_q <= '0;
`ifdef MPS_WRAP_PULSE_EN
      wrap_q <= '0;
`endif
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values of its peers.
      cycle_q <= cycle_d;
      skip_q  <= skip_d;
      sel_q   <= sel_d;
      wcsr_q  <= wcsr_d;
`ifdef MPS_WRAP_PULSE_EN
      wrap_q  <= wrap_d;
`endif
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_out
    assign cycle_o[k*CYC_W +: CYC_W] = cycle_q[k];
    assign mux_sel_o[k*2 +: 2]       = sel_q[k];
  end

  assign wcsr_o = wcsr_q;
`ifdef MPS_WRAP_PULSE_EN
  assign wrap_o = wrap_q;
`else
  assign wrap_o = '0;
`endif

endmodule

// File: tb/tb_mixed_precision_sequencer.sv
// Directed self-checking bench for mixed_precision_sequencer (NCH=2, CYC_W=3, SKIP_W=4).
module tb_mixed_precision_sequencer;

`ifdef MPS_WRAP_PULSE_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       setback_i;
  logic [0:0] ch_sel_i;
  logic [1:0] act_fmt_i, wgt_fmt_i;
  logic [3:0] skip_size_i;
  logic       dotp_valid_i, csr_we_i;
  logic [2:0] csr_wdata_i;
  logic [5:0] cycle_o;
  logic [1:0] wcsr_o, wrap_o;
  logic [3:0] mux_sel_o;

  int n_checks = 0;
  int n_fail   = 0;

  mixed_precision_sequencer #(.NCH(2), .CYC_W(3), .SKIP_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .setback_i    (setback_i),
    .ch_sel_i     (ch_sel_i),
    .act_fmt_i    (act_fmt_i),
    .wgt_fmt_i    (wgt_fmt_i),
    .skip_size_i  (skip_size_i),
    .dotp_valid_i (dotp_valid_i),
    .csr_we_i     (csr_we_i),
    .csr_wdata_i  (csr_wdata_i),
    .cycle_o      (cycle_o),
    .wcsr_o       (wcsr_o),
    .mux_sel_o    (mux_sel_o),
    .wrap_o       (wrap_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock with the given strobes, then sample 1 time unit after the edge.
  task automatic step(input bit dv, input bit we, input int ch, input int wdata);
    ch_sel_i     = 1'(ch);
    dotp_valid_i = dv;
    csr_we_i     = we;
    csr_wdata_i  = 3'(wdata);
    @(posedge clk);
    #1;
    dotp_valid_i = 1'b0;
    csr_we_i     = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic [5:0] cyc, input logic [1:0] wc,
                           input logic [3:0] ms, input logic [1:0] wr);
    check({tag, "_cycle"}, cycle_o, cyc);
    check({tag, "_wcsr"}, wcsr_o, wc);
    check({tag, "_mux"}, mux_sel_o, ms);
    check({tag, "_wrap"}, wrap_o, wr);
  endtask

  int cyc3  [6] = '{0, 0, 1, 1, 1, 0};
  int wcsr3 [6] = '{0, 0, 1, 0, 0, 1};

  initial begin
    rst = 1'b1; setback_i = 1'b0; ch_sel_i = '0; act_fmt_i = '0; wgt_fmt_i = '0;
    skip_size_i = 4'd1; dotp_valid_i = 1'b0; csr_we_i = 1'b0; csr_wdata_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 6'd0, 2'b00, 4'b0000, 2'b00);
    rst = 1'b0;

    // d=3: ch0 counts 1..7, wraps to 0, then 1; ch1 untouched.
    act_fmt_i = 2'd0; wgt_fmt_i = 2'd3; skip_size_i = 4'd1;
    for (int i = 1; i <= 9; i++) begin
      step(1'b1, 1'b0, 0, 0);
      check_all($sformatf("d3_ev%0d", i), {3'd0, 3'(i % 8)}, 2'b01, 4'b0010,
                (i == 8 && WRAP_EN) ? 2'b01 : 2'b00);
    end
    step(1'b0, 1'b0, 0, 0);
    check_all("idle", {3'd0, 3'd1}, 2'b00, 4'b0000, 2'b00);

    // d=1, skip_size=3 on ch1: advance only on the 3rd and 6th events.
    act_fmt_i = 2'd1; wgt_fmt_i = 2'd2; skip_size_i = 4'd3;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 1, 0);
      check_all($sformatf("skip_ev%0d", i + 1), {3'(cyc3[i]), 3'd1},
                (wcsr3[i] != 0) ? 2'b10 : 2'b00, 4'b1000,
                (i == 5 && WRAP_EN) ? 2'b10 : 2'b00);
    end

    // Equal widths: limit 0, clear ch0 first, then events never advance.
    act_fmt_i = 2'd2; wgt_fmt_i = 2'd2; skip_size_i = 4'd1;
    step(1'b0, 1'b1, 0, 0);
    check_all("eq_csr", 6'd0, 2'b00, 4'b0001, 2'b00);
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 1'b0, 0, 0);
      check_all($sformatf("eq_ev%0d", i), 6'd0, 2'b00, 4'b0010, 2'b00);
    end

    // d=2 (limit 3): out-of-range write clears, in-range write loads.
    act_fmt_i = 2'd0; wgt_fmt_i = 2'd2;
    step(1'b0, 1'b1, 0, 5);
    check_all("csr_over", 6'd0, 2'b00, 4'b0001, 2'b00);
    step(1'b0, 1'b1, 0, 2);
    check_all("csr_ok", 6'd2, 2'b00, 4'b0001, 2'b00);

    // d=3, cycle 4 with a pending skip count; simultaneous write wins and clears skip.
    act_fmt_i = 2'd0; wgt_fmt_i = 2'd3;
    step(1'b0, 1'b1, 0, 4);
    check("load4_cycle", cycle_o, 6'd4);
    skip_size_i = 4'd3;
    step(1'b1, 1'b0, 0, 0);
    check_all("pre_skip", 6'd4, 2'b00, 4'b0010, 2'b00);
    step(1'b1, 1'b1, 0, 1);
    check_all("csr_dotp", 6'd1, 2'b00, 4'b0001, 2'b00);
    step(1'b1, 1'b0, 0, 0);
    check_all("post_ev1", 6'd1, 2'b00, 4'b0010, 2'b00);
    step(1'b1, 1'b0, 0, 0);
    check_all("post_ev2", 6'd1, 2'b00, 4'b0010, 2'b00);
    step(1'b1, 1'b0, 0, 0);
    check_all("post_ev3", 6'd2, 2'b01, 4'b0010, 2'b00);

    // setback coincident with a dotp event on ch0 at cycle 5.
    skip_size_i = 4'd1;
    step(1'b0, 1'b1, 1, 3);
    step(1'b0, 1'b1, 0, 5);
    check("pre_setback", cycle_o, {3'd3, 3'd5});
    setback_i = 1'b1;
    step(1'b1, 1'b0, 0, 0);
    setback_i = 1'b0;
    check_all("setback", 6'd0, 2'b00, 4'b0000, 2'b00);

    // Same again with rst.
    step(1'b0, 1'b1, 1, 3);
    step(1'b0, 1'b1, 0, 5);
    check("pre_rst", cycle_o, {3'd3, 3'd5});
    rst = 1'b1;
    step(1'b1, 1'b0, 0, 0);
    rst = 1'b0;
    check_all("rst", 6'd0, 2'b00, 4'b0000, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
